// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin sharing of one multiplier among N_REQ requesters.
// The winner's signed operands are latched and the multiplier runs through a
// start/done handshake. The product then returns to the requester that won.
// Optional feature macro: MULT_SHARE_TIMEOUT_EN builds a WAIT watchdog that
// aborts a multiply after TIMEOUT cycles and flags the result with rsp_err.
//
// Handshake: a requester holds req and its operands until its one-cycle gnt
// pulse; the result comes back as a one-cycle rsp_valid pulse on the same bit,
// with rsp_m and rsp_err valid in that cycle. mul_start is a one-cycle pulse
// and mul_done is accepted only while waiting for it.
module mult_share_ctrl #(
   parameter int D_IN    = 8,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*D_IN-1:0]   a_in,
   input  logic [N_REQ*D_IN-1:0]   b_in,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [2*D_IN-1:0]       rsp_m,
   output logic                    rsp_err,
   output logic                    busy,
   output logic [D_IN-1:0]         mul_a,
   output logic [D_IN-1:0]         mul_b,
   output logic                    mul_start,
   input  logic                    mul_done,
   input  logic [2*D_IN-1:0]       mul_m,
   output logic [1:0]              dbg_state
);

   localparam int PW = $clog2(N_REQ);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   idx;
   logic [PW-1:0]   pick;
   logic [PW-1:0]   cand;
   logic [PW:0]     sum;
   logic            found;
   logic            wd_fire;

   // Elaboration-time guard on the supported parameter range.
   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
      $error("mult_share_ctrl: N_REQ must be 2..8 and TIMEOUT >= 1");
   end

   // Circular search: first requesting index at or after ptr.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sum  = {1'b0, ptr} + (PW+1)'(i);
         cand = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : PW'(sum);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state logic; mul_done outside WAIT is simply never looked at.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (found) state_nx = S_ISSUE;
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  if (mul_done || wd_fire) state_nx = S_RESP;
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State, pointer, captured operands and returned product.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         ptr   <= '0;
         idx   <= '0;
         mul_a <= '0;
         mul_b <= '0;
         rsp_m <= '0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && found) begin
            idx   <= pick;
            mul_a <= a_in[pick*D_IN +: D_IN];
            mul_b <= b_in[pick*D_IN +: D_IN];
         end
         if (state == S_ISSUE) begin
            ptr <= (idx == PW'(N_REQ-1)) ? '0 : idx + 1'b1;
         end
         if (state == S_WAIT) begin
            if (mul_done) begin
               rsp_m <= mul_m;
            end else if (wd_fire) begin
               rsp_m <= '0;
            end
         end
      end
   end

`ifdef MULT_SHARE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wd_cnt;
   logic          err_q;

   // Fires on the last allowed WAIT cycle; a done in the same cycle wins.
   assign wd_fire = (state == S_WAIT) && !mul_done && (wd_cnt == CW'(TIMEOUT - 1));
   assign rsp_err = (state == S_RESP) && err_q;

   // Watchdog counter cleared on WAIT entry; error flag remembered for RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state == S_ISSUE) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
         end else if (state == S_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_fire) err_q <= 1'b1;
         end
      end
   end
`else
   assign wd_fire = 1'b0;
   assign rsp_err = 1'b0;
`endif

   // Pulse outputs decoded from state and the recorded winner index.
   always_comb begin
      gnt       = '0;
      rsp_valid = '0;
      if (state == S_ISSUE) gnt[idx]       = 1'b1;
      if (state == S_RESP)  rsp_valid[idx] = 1'b1;
   end

   assign mul_start = (state == S_ISSUE);
   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: multiplier stub, table-driven single requests,
// directed round-robin / operand-stability / reset / watchdog sequences.
module tb_mult_share_ctrl;

   localparam int D_IN    = 8;
   localparam int N_REQ   = 4;
   localparam int TIMEOUT = 64;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_REQ-1:0]      req;
   logic [N_REQ*D_IN-1:0] a_in, b_in;
   logic [N_REQ-1:0]      gnt, rsp_valid;
   logic [2*D_IN-1:0]     rsp_m;
   logic                  rsp_err, busy;
   logic [D_IN-1:0]       mul_a, mul_b;
   logic                  mul_start;
   logic                  mul_done;
   logic [2*D_IN-1:0]     mul_m;
   logic [1:0]            dbg_state;

   mult_share_ctrl #(.D_IN(D_IN), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_m(rsp_m), .rsp_err(rsp_err),
      .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
      .mul_done(mul_done), .mul_m(mul_m), .dbg_state(dbg_state)
   );

   // Clock / reset block
   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   rsp_cnt = 0;
   bit   stub_on = 1'b1;
   int   stub_lat = 1;

   // Scoreboard: {err, idx[2:0], product[15:0]} and expected grant order
   logic [19:0] exp_q[$];
   logic [2:0]  gnt_q[$];
   logic [19:0] mon_e;
   logic [2:0]  mon_g;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] m;
   } vec_t;
   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // Multiplier stub: done pulse L cycles after start, signed product.
   initial begin : stub
      logic signed [15:0] sa, sb;
      mul_done = 1'b0;
      mul_m    = '0;
      forever begin
         @(posedge clk); #1;
         mul_done = 1'b0;
         if (mul_start === 1'b1 && stub_on) begin
            sa = {{8{mul_a[7]}}, mul_a};
            sb = {{8{mul_b[7]}}, mul_b};
            repeat (stub_lat) @(posedge clk);
            #1;
            mul_done = 1'b1;
            mul_m    = sa * sb;
         end
      end
   end

   // Monitor: pops grant order and responses at the falling edge.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (|gnt) begin
            if (gnt_q.size() == 0) begin
               check("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
               mon_g = gnt_q.pop_front();
               check("gnt_idx", 32'(gnt), 32'(4'b0001 << mon_g));
            end
         end
         if (|rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("rsp_idx", 32'(rsp_valid), 32'(4'b0001 << mon_e[18:16]));
               check("rsp_m", 32'(rsp_m), 32'(mon_e[15:0]));
               check("rsp_err", 32'(rsp_err), 32'(mon_e[19]));
            end
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_rsp(input int limit, output int n);
      n = 0;
      while (n < limit && rsp_valid == '0) begin
         tick();
         n++;
      end
   endtask

   // One isolated request from requester k, checked against the cycle timing.
   task automatic run_one(input int k, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] m, input int lat);
      int n;
      stub_lat = lat;
      a_in[k*D_IN +: D_IN] = a;
      b_in[k*D_IN +: D_IN] = b;
      gnt_q.push_back(3'(k));
      exp_q.push_back({1'b0, 3'(k), m});
      req    = '0;
      req[k] = 1'b1;
      tick();
      check("gnt_cycle", 32'(gnt), 32'(1 << k));
      check("start_cycle", 32'(mul_start), 32'd1);
      check("mul_a_latched", 32'(mul_a), 32'(a));
      check("mul_b_latched", 32'(mul_b), 32'(b));
      req = '0;
      wait_rsp(lat + 10, n);
      check("rsp_latency", 32'(n + 1), 32'(lat + 2));
      tick();
   endtask

   initial begin : global_timer
      #2000000;
      $display("FAIL global_timeout: simulation did not end");
      $fatal(1, "timeout");
   end

   initial begin : main
      int n, cyc, ng, nr0, last_rsp;

      tbl[0] = '{8'h7F, 8'h81, 16'hC0FF};   // 127 * -127
      tbl[1] = '{8'h80, 8'h7F, 16'hC080};   // -128 * 127
      tbl[2] = '{8'h80, 8'h80, 16'h4000};   // -128 * -128
      tbl[3] = '{8'hFB, 8'hF5, 16'h0037};   // -5 * -11
      tbl[4] = '{8'h02, 8'h0A, 16'h0014};   // 2 * 10
      tbl[5] = '{8'h00, 8'hFF, 16'h0000};   // 0 * -1
      tbl[6] = '{8'hFF, 8'hFF, 16'h0001};   // -1 * -1
      tbl[7] = '{8'h7F, 8'h7F, 16'h3F01};   // 127 * 127
      tbl[8] = '{8'h80, 8'h01, 16'hFF80};   // -128 * 1
      tbl[9] = '{8'h01, 8'hFF, 16'hFFFF};   // 1 * -1

      // Reset with all requesters asking; round-robin operands preloaded
      rst  = 1'b1;
      req  = '1;
      a_in = {8'h02, 8'hFB, 8'h80, 8'h80};
      b_in = {8'h0A, 8'hF5, 8'h80, 8'h7F};
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mul_start", 32'(mul_start), 32'd0);
      check("rst_mul_a", 32'(mul_a), 32'd0);
      check("rst_mul_b", 32'(mul_b), 32'd0);
      check("rst_rsp_m", 32'(rsp_m), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);

      // Round-robin: grants 0,1,2,3,0 back to back
      gnt_q.push_back(3'd0); exp_q.push_back({1'b0, 3'd0, 16'hC080});
      gnt_q.push_back(3'd1); exp_q.push_back({1'b0, 3'd1, 16'h4000});
      gnt_q.push_back(3'd2); exp_q.push_back({1'b0, 3'd2, 16'h0037});
      gnt_q.push_back(3'd3); exp_q.push_back({1'b0, 3'd3, 16'h0014});
      gnt_q.push_back(3'd0); exp_q.push_back({1'b0, 3'd0, 16'hC080});
      stub_lat = 3;
      rst = 1'b0;
      cyc = 0; ng = 0; nr0 = rsp_cnt; last_rsp = -100;
      while ((rsp_cnt - nr0) < 5 && cyc < 300) begin
         tick();
         cyc++;
         if (|rsp_valid) last_rsp = cyc;
         if (|gnt) begin
            ng++;
            if (ng == 1) check("first_gnt_cycle", 32'(cyc), 32'd1);
            else         check("b2b_gap", 32'(cyc - last_rsp), 32'd2);
            if (ng == 5) req = '0;
         end
      end
      check("rr_rsp_count", 32'(rsp_cnt - nr0), 32'd5);

      // Table-driven single requests
      for (int i = 0; i < 10; i++) begin
         run_one(i % N_REQ, tbl[i].a, tbl[i].b, tbl[i].m,
                 (i == 0) ? 1 : int'($urandom_range(1, 8)));
      end

      // Operand stability: requester changes its operands during WAIT
      stub_lat = 6;
      a_in[2*D_IN +: D_IN] = 8'hF9;   // -7
      b_in[2*D_IN +: D_IN] = 8'h09;   // 9
      gnt_q.push_back(3'd2);
      exp_q.push_back({1'b0, 3'd2, 16'hFFC1});
      req = 4'b0100;
      tick();
      check("stab_gnt", 32'(gnt), 32'h4);
      req = '0;
      a_in[2*D_IN +: D_IN] = 8'h37;
      b_in[2*D_IN +: D_IN] = 8'hFD;
      repeat (3) begin
         tick();
         check("stab_mul_a", 32'(mul_a), 32'hF9);
         check("stab_mul_b", 32'(mul_b), 32'h09);
      end
      wait_rsp(20, n);
      check("stab_rsp_seen", 32'(|rsp_valid), 32'd1);
      tick();

      // Reset during WAIT: no response, ptr back to 0
      stub_lat = 20;
      a_in[1*D_IN +: D_IN] = 8'h05;
      b_in[1*D_IN +: D_IN] = 8'h05;
      gnt_q.push_back(3'd1);
      req = 4'b0010;
      tick();
      check("mid_gnt", 32'(gnt), 32'h2);
      req = '0;
      repeat (3) tick();
      check("mid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      check("mid_rst_state", 32'(dbg_state), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_rsp_m", 32'(rsp_m), 32'd0);
      check("mid_rst_mul_a", 32'(mul_a), 32'd0);
      rst = 1'b0;
      repeat (25) tick();
      stub_lat = 2;
      a_in = {8'h11, 8'h22, 8'h33, 8'h03};   // requester 0: 3
      b_in = {8'h01, 8'h01, 8'h01, 8'hFC};   // requester 0: -4
      gnt_q.push_back(3'd0);
      exp_q.push_back({1'b0, 3'd0, 16'hFFF4});
      req = '1;
      tick();
      check("gnt_after_rst", 32'(gnt), 32'h1);
      req = '0;
      wait_rsp(20, n);
      check("after_rst_latency", 32'(n + 1), 32'd4);
      tick();

      // Multiplier that never answers
      stub_on = 1'b0;
      a_in[3*D_IN +: D_IN] = 8'h05;
      b_in[3*D_IN +: D_IN] = 8'h06;
      gnt_q.push_back(3'd3);
`ifdef MULT_SHARE_TIMEOUT_EN
      exp_q.push_back({1'b1, 3'd3, 16'h0000});
      req = 4'b1000;
      tick();
      check("wd_gnt", 32'(gnt), 32'h8);
      req = '0;
      wait_rsp(TIMEOUT + 20, n);
      check("wd_latency", 32'(n + 1), 32'(TIMEOUT + 2));
      tick();
`else
      req = 4'b1000;
      tick();
      check("hang_gnt", 32'(gnt), 32'h8);
      req = '0;
      repeat (200) tick();
      check("hang_busy", 32'(busy), 32'd1);
      check("hang_state", 32'(dbg_state), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("hang_recover_busy", 32'(busy), 32'd0);
`endif
      stub_on = 1'b1;
      repeat (3) tick();

      // Final report
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      check("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Round-robin controller that shares one `booth_mult` instance among `N_REQ` requesters. It arbitrates requests, latches the winner's signed operands, sequences the multiplier through a start/done handshake, and returns the product to the granted requester. It sits between the requester ports and the single multiplier datapath. An optional watchdog aborts multiplies that never complete.

## Interface
- `D_IN`, 8, operand width; product width is 2*D_IN
- `N_REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, maximum cycles in WAIT before abort (watchdog only)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  one clock; reset is synchronous and active-high
- `req`  in  N_REQ  per-requester request level
- `a_in`  in  N_REQ*D_IN  signed operand A; requester k uses slice [k*D_IN +: D_IN]
- `b_in`  in  N_REQ*D_IN  signed operand B; same slicing
- `gnt`  out  N_REQ  one-hot, 1-cycle pulse: operands of k captured
- `rsp_valid`  out  N_REQ  one-hot, 1-cycle pulse: product for k on `rsp_m`
- `rsp_m`  out  2*D_IN  signed product; holds its value until the next RESP
- `rsp_err`  out  1  high with `rsp_valid` when the result was aborted
- `busy`  out  1  high in every state except IDLE
- `mul_a`, `mul_b`  out  D_IN each  operands to the multiplier
- `mul_start`  out  1  1-cycle start pulse to the multiplier
- `mul_done`  in  1  1-cycle completion pulse from the multiplier
- `mul_m`  in  2*D_IN  product; valid in the `mul_done` cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req` is high, select the first requester at or after `ptr` (circular search).
  - Latch its operands into `mul_a`/`mul_b`, record the index, then go to ISSUE.
- ISSUE:
  - `gnt[k]`=1 and `mul_start`=1 for one cycle.
  - Set `ptr` = (k+1) mod N_REQ.
  - Go to WAIT.
- WAIT:
  - On `mul_done`, capture `mul_m` into `rsp_m` and go to RESP.
  - `mul_done` seen in any other state is ignored.
- RESP:
  - `rsp_valid[k]`=1 for one cycle, then go to IDLE.
- `mul_a`/`mul_b` stay stable from ISSUE through WAIT. They change only when the next grant is latched.
- Arithmetic: operands are two's complement. The product passes through unmodified at 2*D_IN bits, with no saturation.
- A requester must hold `req` and its operands until its `gnt` pulse.
  - If `req` drops before the grant is latched, no grant is issued.
  - `req` changes during ISSUE, WAIT and RESP have no effect.
- Requester k holding `req` continuously is re-arbitrated in the next IDLE and gets lowest priority, because `ptr` = k+1.
- Reset (any state, including mid-multiply):
  - The FSM returns to IDLE and `ptr` = 0.
  - `gnt`, `rsp_valid`, `rsp_err`, `busy`, `mul_start` = 0.
  - `mul_a`, `mul_b`, `rsp_m` = 0.
  - The multiplier shares `rst`. A stale `mul_done` after reset is ignored because the FSM is in IDLE.

## Timing
- Let t be an IDLE cycle with a qualifying `req`:
  - Operands are captured at the end of t.
  - `gnt` and `mul_start` are high in t+1.
- Let L (L≥1) be the number of cycles from `mul_start` to `mul_done`. `mul_done` arrives in cycle t+1+L.
- `rsp_valid` and `rsp_m` appear in t+2+L. IDLE is re-entered at t+3+L.
- Back-to-back requests: the next `gnt` comes 2 cycles after `rsp_valid`.
- Only one multiply is in flight. There is no pipelining.
- `mul_done` in the ISSUE cycle cannot occur (L≥1) and is ignored.

## Configuration
- `MULT_SHARE_TIMEOUT_EN` defined:
  - A counter starts at 0 on WAIT entry.
  - If it reaches `TIMEOUT` without `mul_done`, go to RESP with `rsp_m`=0 and `rsp_err`=1.
  - A late `mul_done` is ignored.
- `MULT_SHARE_TIMEOUT_EN` undefined:
  - No counter is built and `rsp_err` is tied to 0.
  - WAIT is left only on `mul_done`.

## Test plan
- Reset behaviour: hold `rst` for 2 cycles with `req`=all ones -> all outputs 0. The first `gnt` after reset release goes to requester 0.
- Single request: req[0] with A=127, B=-127 -> `mul_start` 1 cycle after the request is sampled. `rsp_valid[0]` arrives with `rsp_m`=16'hC0FF (-16129), exactly L+2 cycles after the request.
- Round-robin: all 4 requesters high, with (A,B) = (-128,127), (-128,-128), (-5,-11), (2,10) -> grant order 0,1,2,3,0. Products are 16'hC080, 16'h4000, 16'h0037, 16'h0014, each returned on the matching `rsp_valid` bit.
- Operand stability: change `a_in`/`b_in` of the granted requester during WAIT -> `mul_a`/`mul_b` unchanged and the product matches the captured operands.
- Reset mid-operation: assert `rst` during WAIT -> IDLE next cycle, `ptr`=0, and no `rsp_valid`. A following request completes correctly.
- Watchdog (`MULT_SHARE_TIMEOUT_EN`, TIMEOUT=64, multiplier stub never asserts `mul_done`) -> `rsp_valid[k]` with `rsp_err`=1 and `rsp_m`=0, 64 cycles after WAIT entry. Without the macro, `busy` stays high indefinitely.
